imem_load_ctrl: RTL and testbench

- Owns the instruction RAM port and the fetch-stage enable for the pipelined CPU.
- Either streams a program from the debug UART byte channel into the instruction RAM, or hands the RAM port to fetch and gates PC advance.
- Command pulses from the debug unit select the mode: load, run, single-step or halt.
- Sits between the debug unit, the fetch stage (PC register enable/clear) and the instruction RAM.

---
 rtl/imem_load_ctrl.sv | 153 +++++++++++++++
 tb/tb_imem_load_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// Instruction RAM port owner: streams a program from the debug UART into RAM, or hands the port to fetch.
// Optional IMEM_LOAD_CSUM_EN adds load_csum, the mod-256 sum of bytes accepted in the current load.
module imem_load_ctrl #(
    parameter int              AW       = 9,
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   END_WORD = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_load,
    input  logic          cmd_run,
    input  logic          cmd_step,
    input  logic          cmd_halt,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic [AW-1:0] pcf,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          fetch_en,
    output logic          pc_clr,
    output logic          busy,
    output logic [AW:0]   load_words,
    output logic [2:0]    state_o
`ifdef IMEM_LOAD_CSUM_EN
    ,
    output logic [7:0]    load_csum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_HALT = 3'd3,
        S_STEP = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    bcnt_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] asm_q;
    logic [DW-1:0] wdata_q;
    logic          wr_pend_q;
    logic          pc_clr_q;
    logic [AW:0]   load_words_q;
`ifdef IMEM_LOAD_CSUM_EN
    logic [7:0]    csum_q;
`endif

    logic [DW-1:0] asm_next;
    logic          wr_last;
    logic          load_entry;
    logic          in_load;

    assign asm_next   = {asm_q[DW-9:0], rx_data};
    assign in_load    = (state_q == S_LOAD);
    // The pending write closes the load if it carries the end marker or hits the top address.
    assign wr_last    = wr_pend_q && ((wdata_q == END_WORD) || (waddr_q == {AW{1'b1}}));
    assign load_entry = cmd_load && (state_q != S_STEP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_load)      state_d = S_LOAD;
                else if (cmd_halt) state_d = S_IDLE;
                else if (cmd_step) state_d = S_STEP;
                else if (cmd_run)  state_d = S_RUN;
            end
            S_LOAD: begin
                if (cmd_load)                state_d = S_LOAD;
                else if (cmd_halt || wr_last) state_d = S_HALT;
            end
            S_RUN: begin
                if (cmd_load)      state_d = S_LOAD;
                else if (cmd_halt) state_d = S_HALT;
            end
            S_HALT: begin
                if (cmd_load)      state_d = S_LOAD;
                else if (cmd_halt) state_d = S_HALT;
                else if (cmd_step) state_d = S_STEP;
                else if (cmd_run)  state_d = S_RUN;
            end
            S_STEP:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bcnt_q       <= 2'd0;
            waddr_q      <= '0;
            asm_q        <= '0;
            wdata_q      <= '0;
            wr_pend_q    <= 1'b0;
            pc_clr_q     <= 1'b1;
            load_words_q <= '0;
`ifdef IMEM_LOAD_CSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            pc_clr_q <= load_entry;
            if (load_entry) begin
                bcnt_q       <= 2'd0;
                waddr_q      <= '0;
                asm_q        <= '0;
                wr_pend_q    <= 1'b0;
                load_words_q <= '0;
`ifdef IMEM_LOAD_CSUM_EN
                csum_q       <= 8'd0;
`endif
            end else if (in_load) begin
                if (wr_pend_q) begin
                    waddr_q      <= waddr_q + 1'b1;
                    load_words_q <= load_words_q + 1'b1;
                end
                // A completed word is only queued if the load continues; a halt discards it.
                wr_pend_q <= rx_valid && (bcnt_q == 2'd3) && (state_d == S_LOAD);
                if (rx_valid) begin
                    asm_q  <= asm_next;
                    bcnt_q <= bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3)
                        wdata_q <= asm_next;
`ifdef IMEM_LOAD_CSUM_EN
                    csum_q <= csum_q + rx_data;
`endif
                end
            end else begin
                wr_pend_q <= 1'b0;
            end
        end
    end

    // RAM and fetch strobes are forced low while reset is asserted so no write escapes a reset.
    assign mem_we     = in_load && wr_pend_q && !reset;
    assign mem_en     = !reset && (mem_we || (state_q == S_RUN) || (state_q == S_HALT)
                                          || (state_q == S_STEP));
    assign fetch_en   = !reset && ((state_q == S_RUN) || (state_q == S_STEP));
    assign mem_addr   = in_load ? waddr_q : ((state_q == S_IDLE) ? '0 : pcf);
    assign mem_din    = mem_we ? wdata_q : '0;
    assign pc_clr     = pc_clr_q;
    assign busy       = in_load;
    assign load_words = load_words_q;
    assign state_o    = state_q;
`ifdef IMEM_LOAD_CSUM_EN
    assign load_csum  = csum_q;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized self-checking bench for imem_load_ctrl; expected RAM writes are derived from the byte stream.
module tb_imem_load_ctrl;
    localparam int          AW   = 9;
    localparam logic [31:0] ENDW = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset, cmd_load, cmd_run, cmd_step, cmd_halt, rx_valid;
    logic [7:0]    rx_data;
    logic [AW-1:0] pcf;
    logic          mem_en, mem_we, fetch_en, pc_clr, busy;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [AW:0]   load_words;
    logic [2:0]    state_o;
`ifdef IMEM_LOAD_CSUM_EN
    logic [7:0]    load_csum;
`endif

    always #5 clk = ~clk;

    imem_load_ctrl #(.AW(AW), .DW(32), .END_WORD(ENDW)) dut (
        .clk(clk), .reset(reset), .cmd_load(cmd_load), .cmd_run(cmd_run),
        .cmd_step(cmd_step), .cmd_halt(cmd_halt), .rx_data(rx_data), .rx_valid(rx_valid),
        .pcf(pcf), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .fetch_en(fetch_en), .pc_clr(pc_clr), .busy(busy), .load_words(load_words),
        .state_o(state_o)
`ifdef IMEM_LOAD_CSUM_EN
        , .load_csum(load_csum)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write and fetch-enable monitor, sampled on the falling edge.
    int            wr_n     = 0;
    int            fe_total = 0;
    logic [AW-1:0] wr_addr [0:4095];
    logic [31:0]   wr_data [0:4095];

    always @(negedge clk) begin
        if (mem_en && mem_we) begin
            if (wr_n < 4096) begin
                wr_addr[wr_n] <= mem_addr;
                wr_data[wr_n] <= mem_din;
            end
            wr_n <= wr_n + 1;
        end
        if (fetch_en) fe_total <= fe_total + 1;
    end

    logic [7:0] byte_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ld, input logic rn, input logic st, input logic hl);
        cmd_load = ld; cmd_run = rn; cmd_step = st; cmd_halt = hl;
        tick();
        cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        byte_q.push_back(w[31:24]);
        byte_q.push_back(w[23:16]);
        byte_q.push_back(w[15:8]);
        byte_q.push_back(w[7:0]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == ENDW) w = 32'h0;
        return w;
    endfunction

    task automatic send_bytes();
        foreach (byte_q[i]) begin
            repeat ($urandom_range(0, 2)) tick();
            rx_valid = 1'b1;
            rx_data  = byte_q[i];
            tick();
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] exp, input int limit);
        int k = 0;
        while (state_o !== exp && k < limit) begin
            tick();
            k++;
        end
        check(tag, state_o, exp);
    endtask

    // Reference: whole words in stream order at addresses 0,1,..; stop after END_WORD or the top address.
    task automatic check_load(input string tag, input int base);
        int          n    = 0;
        bit          done = 1'b0;
        logic [31:0] w;
        for (int i = 0; i + 3 < byte_q.size() && !done; i += 4) begin
            w = {byte_q[i], byte_q[i+1], byte_q[i+2], byte_q[i+3]};
            if (base + n < 4096) begin
                check({tag, "_addr"}, wr_addr[base+n], n);
                check({tag, "_data"}, wr_data[base+n], w);
            end
            n++;
            if (w == ENDW || n == (1 << AW)) done = 1'b1;
        end
        check({tag, "_nwr"}, wr_n - base, n);
        check({tag, "_load_words"}, load_words, n);
`ifdef IMEM_LOAD_CSUM_EN
        begin
            logic [7:0] s = 8'd0;
            foreach (byte_q[i]) s = s + byte_q[i];
            check({tag, "_csum"}, load_csum, s);
        end
`endif
    endtask

    initial begin
        int base, fbase, nw, part;
        logic [AW-1:0] p;
        reset = 1'b1; cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; pcf = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_state", state_o, 3'd0);
        check("rst_pc_clr", pc_clr, 1'b1);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_fetch_en", fetch_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_load_words", load_words, 0);
        tick();
        check("rst_pc_clr_drop", pc_clr, 1'b0);

        // Directed program load ending in the end marker.
        byte_q = {8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        base = wr_n;
        pulse(1, 0, 0, 0);
        check("ld_state", state_o, 3'd1);
        check("ld_busy", busy, 1'b1);
        check("ld_pc_clr", pc_clr, 1'b1);
        tick();
        check("ld_pc_clr_once", pc_clr, 1'b0);
        send_bytes();
        wait_state("ld_halt", 3'd3, 20);
        check("ld_busy_low", busy, 1'b0);
        check_load("ld", base);

        // Single step from HALT.
        pcf = 9'd5;
        fbase = fe_total;
        pulse(0, 0, 1, 0);
        check("step_state", state_o, 3'd4);
        check("step_fetch", fetch_en, 1'b1);
        check("step_addr", mem_addr, 9'd5);
        tick();
        check("step_back", state_o, 3'd3);
        check("step_fetch_off", fetch_en, 1'b0);
        check("halt_mem_en", mem_en, 1'b1);
        repeat (3) tick();
        check("step_count1", fe_total - fbase, 1);
        pulse(0, 0, 1, 0);
        repeat (4) tick();
        check("step_count2", fe_total - fbase, 2);
        pulse(0, 0, 1, 1);
        check("prio_halt_over_step", state_o, 3'd3);
        pulse(0, 1, 1, 0);
        check("prio_step_over_run", state_o, 3'd4);
        tick();

        // Free run for N cycles, then halt.
        for (int r = 0; r < 3; r++) begin
            nw = (r == 0) ? 10 : $urandom_range(1, 30);
            fbase = fe_total;
            pulse(0, 1, 0, 0);
            check("run_state", state_o, 3'd2);
            p = 9'($urandom);
            pcf = p;
            #1;
            check("run_addr", mem_addr, p);
            repeat (nw - 1) tick();
            pulse(0, 0, 0, 1);
            check("run_halted", state_o, 3'd3);
            repeat (3) tick();
            check("run_count", fe_total - fbase, nw);
        end

        // Halt during a partial word.
        byte_q = {8'h01, 8'h02};
        base = wr_n;
        pulse(1, 0, 0, 0);
        tick();
        send_bytes();
        pulse(0, 0, 0, 1);
        check("part_state", state_o, 3'd3);
        tick();
        check_load("part", base);

        // Simultaneous run and load from HALT.
        pulse(1, 1, 0, 0);
        check("sim_state", state_o, 3'd1);
        check("sim_pc_clr", pc_clr, 1'b1);
        check("sim_fetch", fetch_en, 1'b0);
        pulse(0, 0, 0, 1);
        check("sim_halt", state_o, 3'd3);

        // Random loads, ending by marker or by halt after a partial word.
        for (int r = 0; r < 6; r++) begin
            byte_q.delete();
            nw = $urandom_range(1, 12);
            for (int k = 0; k < nw; k++) push_word(rand_word());
            part = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) push_word(ENDW);
            else for (int k = 0; k < part; k++) byte_q.push_back(8'($urandom));
            base = wr_n;
            pulse(1, 0, 0, 0);
            tick();
            send_bytes();
            if (byte_q.size() >= 4 && {byte_q[byte_q.size()-4], byte_q[byte_q.size()-3],
                                       byte_q[byte_q.size()-2], byte_q[byte_q.size()-1]} == ENDW)
                wait_state("rnd_halt_end", 3'd3, 20);
            else
                pulse(0, 0, 0, 1);
            check("rnd_state", state_o, 3'd3);
            tick();
            check_load("rnd", base);
        end

        // Reset in the middle of the second word.
        byte_q.delete();
        push_word(rand_word());
        byte_q.push_back(8'($urandom));
        byte_q.push_back(8'($urandom));
        base = wr_n;
        pulse(1, 0, 0, 0);
        tick();
        send_bytes();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_state", state_o, 3'd0);
        check("mrst_pc_clr", pc_clr, 1'b1);
        check("mrst_mem_en", mem_en, 1'b0);
        check("mrst_mem_we", mem_we, 1'b0);
        check("mrst_fetch", fetch_en, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_load_words", load_words, 0);
        check("mrst_mem_addr", mem_addr, 0);
        check("mrst_mem_din", mem_din, 0);
        repeat (2) tick();
        check("mrst_nwr", wr_n - base, 1);
        check("mrst_word0", wr_data[base], {byte_q[0], byte_q[1], byte_q[2], byte_q[3]});

        // Full RAM without a marker: load stops after the top address.
        byte_q.delete();
        for (int k = 0; k < (1 << AW); k++) push_word(rand_word());
        base = wr_n;
        pulse(1, 0, 0, 0);
        tick();
        send_bytes();
        wait_state("full_halt", 3'd3, 20);
        check_load("full", base);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
